lzc_arbiter: RTL and testbench

LZC_ARBITER -- requirements
Module: lzc_arbiter

---
 rtl/lzc_arb_pkg.sv | 30 +++
 rtl/LZC_32_bit.sv | 24 ++
 rtl/lzc_arbiter.sv | 128 ++++++++++++
 tb/tb_lzc_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzc_arb_pkg.sv
// Shared types and constants for the two-requester LZC arbiter.
// Holds the FSM state encoding plus the arbitration and one-hot helper functions.
package lzc_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int OP_W    = 32;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Round-robin pick: on a tie the requester that did not win last time goes next.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] valid, input logic last);
    logic pick;
    if (valid == 2'b11) begin
      pick = ~last;
    end else begin
      pick = valid[1];
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/LZC_32_bit.sv
// Existing 32-bit leading-zero counter: Z is the number of zeros above the first set bit,
// V is high when any bit of a is set (a == 0 gives Z = 0, V = 0).
module LZC_32_bit (
  input  logic [31:0] a,
  output logic [4:0]  Z,
  output logic        V
);

  logic found;

  always_comb begin
    Z     = 5'd0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!found && a[31-i]) begin
        Z     = 5'(i);
        found = 1'b1;
      end
    end
  end

  assign V = found;

endmodule

// File: rtl/lzc_arbiter.sv
// Round-robin arbiter sharing one LZC_32_bit between two requesters, one operation in flight.
// Optional per-requester grant counters are built when LZC_ARB_STATS_EN is defined.
module lzc_arbiter
  import lzc_arb_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [4:0]  rsp_z,
  output logic        rsp_v
`ifdef LZC_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt0,
  output logic [STAT_W-1:0] grant_cnt1
`endif
);

  state_t            state;
  state_t            state_next;
  logic [OP_W-1:0]   operand;
  logic              grant;
  logic              last_grant;
  logic              pick;
  logic              accept;
  logic              load_rsp;
  logic              rsp_done;
  logic [1:0]        ready_raw;
  logic [CNT_W-1:0]  lzc_z;
  logic              lzc_v;

  always_comb pick = rr_pick(req_valid, last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready_raw  = 2'b00;
    accept     = 1'b0;
    load_rsp   = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          ready_raw  = grant_onehot(pick);
          accept     = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL: begin
        load_rsp   = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        // Only the granted requester's rsp_ready can retire the response.
        if (rsp_ready[grant]) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset is asynchronous, so ready must also be masked combinationally while rst_n is low.
  assign req_ready = ready_raw & {2{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand    <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 2'b00;
      rsp_z      <= '0;
      rsp_v      <= 1'b0;
    end else begin
      if (accept) begin
        operand    <= pick ? req_data1 : req_data0;
        grant      <= pick;
        last_grant <= pick;
      end
      if (load_rsp) begin
        rsp_z     <= lzc_z;
        rsp_v     <= lzc_v;
        rsp_valid <= grant_onehot(grant);
      end
      if (rsp_done) begin
        rsp_valid <= 2'b00;
      end
    end
  end

  LZC_32_bit u_lzc (
    .a (operand),
    .Z (lzc_z),
    .V (lzc_v)
  );

`ifdef LZC_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_cnt[gi] <= '0;
      end else if (accept && (pick == 1'(gi)) && (grant_cnt[gi] != '1)) begin
        grant_cnt[gi] <= grant_cnt[gi] + STAT_W'(1);
      end
    end
  end

  assign grant_cnt0 = grant_cnt[0];
  assign grant_cnt1 = grant_cnt[1];
`endif

endmodule

// File: tb/tb_lzc_arbiter.sv
// Scoreboard bench for lzc_arbiter: accepts push expected results, response handshakes pop them.
// Define LZC_ARB_STATS_EN to also exercise the saturating grant counters with STAT_W = 2.
module tb_lzc_arbiter;

`ifdef LZC_ARB_STATS_EN
  localparam int SW = 2;
`else
  localparam int SW = 16;
`endif

  typedef struct {
    logic       idx;
    logic [4:0] z;
    logic       v;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_data0 = '0;
  logic [31:0] req_data1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [4:0]  rsp_z;
  logic        rsp_v;
`ifdef LZC_ARB_STATS_EN
  logic [SW-1:0] grant_cnt0;
  logic [SW-1:0] grant_cnt1;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   log_idx[$];
  int   log_cyc[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [1:0] prev_rsp = 2'b00;

  lzc_arbiter #(.STAT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_v     (rsp_v)
`ifdef LZC_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference LZC: shift left until the MSB is set.
  function automatic logic [5:0] lzc_ref(input logic [31:0] a);
    logic [31:0] x;
    int n;
    x = a;
    n = 0;
    if (x == 32'd0) return 6'd0;
    while (!x[31]) begin
      x = x << 1;
      n++;
    end
    return {1'b1, 5'(n)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_rsp = 2'b00;
    end else begin
      cyc++;
      check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (rsp_valid != 2'b00 && prev_rsp == 2'b00) begin
        if (sb.size() == 0) check("spurious_rsp", 32'(rsp_valid), 32'd0);
        else check("latency", 32'(cyc - sb[0].cyc), 32'd2);
      end
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (sb.size() == 0) begin
          check("rsp_no_expect", 32'(rsp_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_valid", 32'(rsp_valid), mon_e.idx ? 32'd2 : 32'd1);
          check("rsp_z", 32'(rsp_z), 32'(mon_e.z));
          check("rsp_v", 32'(rsp_v), 32'(mon_e.v));
          $display("[TB] rsp req%0d z=%0d v=%0b", mon_e.idx, rsp_z, rsp_v);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          logic [5:0] r;
          r = lzc_ref(i == 0 ? req_data0 : req_data1);
          mon_e.idx = 1'(i);
          mon_e.z   = r[4:0];
          mon_e.v   = r[5];
          mon_e.cyc = cyc;
          sb.push_back(mon_e);
          log_idx.push_back(i);
          log_cyc.push_back(cyc);
          $display("[TB] accept req%0d data=%08h cyc=%0d", i, i == 0 ? req_data0 : req_data1, cyc);
        end
      end
      prev_rsp = rsp_valid;
    end
  end

  task automatic send(input int idx, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if (idx == 0) req_data0 = d; else req_data1 = d;
    req_valid[idx] = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[idx]) ok = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && rsp_valid == 2'b00) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [4:0] z_hold;
    logic       v_hold;
    logic [1:0] val_hold;
    bit         seen;

    // Reset state, with both requesters asserting valid.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_z", 32'(rsp_z), 32'd0);
    check("rst_rsp_v", 32'(rsp_v), 32'd0);
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(0, 32'h8000_0000);
    wait_idle();
    send(1, 32'h0000_0001);
    wait_idle();
    send(0, 32'h0000_0000);
    wait_idle();
    send(0, 32'hFFFF_FFFF);
    wait_idle();
    send(1, 32'h0001_0000);
    wait_idle();
    send(0, $urandom());
    wait_idle();
    send(1, $urandom() >> 7);
    wait_idle();

    // Continuous contention: grants must alternate starting at req0, one every 3 cycles.
    log_idx.delete();
    log_cyc.delete();
    @(posedge clk); #1;
    req_data0 = 32'h0000_00F0;
    req_data1 = 32'h0F00_0000;
    req_valid = 2'b11;
    repeat (13) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
    check("alt_count", 32'(log_idx.size() >= 4), 32'd1);
    if (log_idx.size() > 0) check("alt_first", 32'(log_idx[0]), 32'd0);
    for (int k = 1; k < log_idx.size(); k++) begin
      check("alt_grant", 32'(log_idx[k]), 32'(1 - log_idx[k-1]));
      check("alt_gap", 32'(log_cyc[k] - log_cyc[k-1]), 32'd3);
    end

    // Hold: only the non-granted rsp_ready is high, so the response must stay put.
    rsp_ready = 2'b10;
    send(0, 32'h0000_0F00);
    req_data1 = 32'h0000_0003;
    req_valid[1] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      check("hold_wait_ready", 32'(req_ready), 32'd0);
      if (rsp_valid != 2'b00) seen = 1'b1;
    end
    check("hold_seen", 32'(seen), 32'd1);
    val_hold = rsp_valid;
    z_hold   = rsp_z;
    v_hold   = rsp_v;
    check("hold_valid0", 32'(val_hold), 32'd1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'(val_hold));
      check("hold_z", 32'(rsp_z), 32'(z_hold));
      check("hold_v", 32'(rsp_v), 32'(v_hold));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    @(negedge clk);
    check("complete_only", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("next_in_idle", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_idle();

    // Reset while EVAL: the operand is dropped and the next tie goes to req0.
    send(0, 32'h0000_0040);
    wait_idle();
    @(posedge clk); #1;
    req_data0 = 32'h0000_1000;
    req_valid = 2'b01;
    @(negedge clk);
    check("pre_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    req_data0 = 32'h0000_0100;
    req_data1 = 32'h0010_0000;
    req_valid = 2'b11;
    @(negedge clk);
    check("post_rst_tie", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();

`ifdef LZC_ARB_STATS_EN
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("cnt0_rst", 32'(grant_cnt0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(0, 32'h0000_0001 << k);
      wait_idle();
      if (k == 1) check("cnt0_two", 32'(grant_cnt0), 32'd2);
    end
    check("cnt0_sat", 32'(grant_cnt0), 32'd3);
    check("cnt1_zero", 32'(grant_cnt1), 32'd0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
